// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling constants and a
// width helper for counters sized from parameters.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;  // ticks per bit period
    localparam int unsigned START_MID  = 7;   // tick index at mid start bit

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Bits needed to hold 0..v-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, shared by the RX and TX paths.
//   clk       : system clock
//   reset_pin : asynchronous active-low reset
//   tick      : one-cycle pulse every DVSR clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DVSR = 27
) (
    input  logic clk,
    input  logic reset_pin,
    output logic tick
);

    localparam int unsigned CNT_W = clog2(DVSR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DVSR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap after DVSR-1 back to zero.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    // tick is registered from the next count so it is high exactly while
    // the counter sits at DVSR-1.
    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tick  <= (cnt_d == CNT_MAX);
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, oversamples at 16x, checks start
// and stop bits and writes each good byte into the RX FIFO.
//   clk, reset_pin : clock, asynchronous active-low reset
//   rx             : raw serial input, idle high
//   fifo_full      : RX FIFO full, looked at only when the stop bit is judged
//   clear_err      : clears the sticky error flags
//   wr_rx, w_data  : one-cycle FIFO write strobe and its byte
//   rx_busy        : a frame is in progress
//   frame_err      : sticky, stop bit sampled low
//   overrun_err    : sticky, good byte dropped because the FIFO was full
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned DVSR    = 27,
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_pin,
    input  logic            rx,
    input  logic            fifo_full,
    input  logic            clear_err,
    output logic            wr_rx,
    output logic [DBIT-1:0] w_data,
    output logic            rx_busy,
    output logic            frame_err,
    output logic            overrun_err
);

    localparam int unsigned S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int unsigned S_W   = clog2(S_MAX);
    localparam int unsigned N_W   = clog2(DBIT);

    logic            tick;
    logic            rx_meta;
    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            wr_d;
    logic [DBIT-1:0] w_data_d;
    logic            ferr_set;
    logic            oerr_set;

    uart_baud_tick #(
        .DVSR (DVSR)
    ) u_tick (
        .clk       (clk),
        .reset_pin (reset_pin),
        .tick      (tick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        shift_d  = shift_q;
        wr_d     = 1'b0;
        w_data_d = w_data;
        ferr_set = 1'b0;
        oerr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_W'(START_MID)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;  // too short to be a start bit
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_W'(OVERSAMPLE - 1)) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_q == N_W'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            state_d = IDLE;
                            if (fifo_full) begin
                                oerr_set = 1'b1;
                            end else begin
                                wr_d     = 1'b1;
                                w_data_d = shift_q;
                            end
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = BREAK;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            BREAK: begin
                // Hold here until the line recovers so a break is one error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; a new error wins over clear_err.
    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            wr_rx       <= 1'b0;
            w_data      <= '0;
            rx_busy     <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            wr_rx       <= wr_d;
            w_data      <= w_data_d;
            rx_busy     <= (state_d != IDLE);
            frame_err   <= ferr_set | (frame_err & ~clear_err);
            overrun_err <= oerr_set | (overrun_err & ~clear_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at DVSR=4, DBIT=8: directed
// scenarios followed by random frames against a frame-level model.
module tb_uart_rx_deframer;

    localparam int unsigned DVSR    = 4;
    localparam int unsigned DBIT    = 8;
    localparam int unsigned SB_TICK = 16;
    localparam int unsigned BIT_CYC = 16 * DVSR;
    localparam int LAT_MIN = (8 + 16 * DBIT + SB_TICK) * DVSR;
    localparam int LAT_MAX = 2 + LAT_MIN + DVSR - 1;

    logic            clk = 1'b0;
    logic            reset_pin = 1'b0;
    logic            rx = 1'b1;
    logic            fifo_full = 1'b0;
    logic            clear_err = 1'b0;
    logic            wr_rx;
    logic [DBIT-1:0] w_data;
    logic            rx_busy;
    logic            frame_err;
    logic            overrun_err;

    uart_rx_deframer #(
        .DVSR    (DVSR),
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk         (clk),
        .reset_pin   (reset_pin),
        .rx          (rx),
        .fifo_full   (fifo_full),
        .clear_err   (clear_err),
        .wr_rx       (wr_rx),
        .w_data      (w_data),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Monitor-owned observations.
    logic [7:0] got_mem [256];
    int wr_cnt = 0;
    int busy_cnt = 0;
    int double_cnt = 0;
    int last_wr_cyc = 0;
    logic prev_wr = 1'b0;

    // Model-owned expectations.
    logic [7:0] exp_mem [256];
    int exp_cnt = 0;
    int rd_idx = 0;
    logic exp_ferr = 1'b0;
    logic exp_oerr = 1'b0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_busy) busy_cnt++;
        if (wr_rx) begin
            if (prev_wr) double_cnt++;
            if (wr_cnt < 256) got_mem[wr_cnt] = w_data;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        prev_wr = wr_rx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial frame on rx; the model decides the outcome from line-level facts.
    task automatic send_frame(input logic [7:0] d, input logic good_stop, input int extra_low);
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < int'(DBIT); i++) begin
            rx = d[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = good_stop;
        repeat (BIT_CYC + (good_stop ? 0 : extra_low)) @(negedge clk);
        if (!good_stop && extra_low > 0) begin
            check("break_busy", 32'(rx_busy), 32'd1);
            check("break_frame_err", 32'(frame_err), 32'd1);
        end
        rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        if (!good_stop) begin
            exp_ferr = 1'b1;
        end else if (fifo_full) begin
            exp_oerr = 1'b1;
        end else begin
            exp_mem[exp_cnt] = d;
            exp_cnt++;
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_wr_count"}, 32'(wr_cnt), 32'(exp_cnt));
        while (rd_idx < wr_cnt && rd_idx < exp_cnt) begin
            check({tag, "_data"}, 32'(got_mem[rd_idx]), 32'(exp_mem[rd_idx]));
            rd_idx++;
        end
        if (wr_cnt > exp_cnt) exp_cnt = wr_cnt;
        rd_idx = exp_cnt;
        check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, "_overrun_err"}, 32'(overrun_err), 32'(exp_oerr));
        check({tag, "_busy"}, 32'(rx_busy), 32'd0);
    endtask

    task automatic pulse_clear(input string tag);
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_ferr = 1'b0;
        exp_oerr = 1'b0;
        @(negedge clk);
        check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, "_overrun_err"}, 32'(overrun_err), 32'(exp_oerr));
    endtask

    initial begin
        #1000000;
        $fatal(1, "FAIL timeout: bench did not complete");
    end

    initial begin
        int snap;
        int lat;
        logic [7:0] d;
        logic good;
        logic full;

        // Reset and idle line.
        repeat (5) @(negedge clk);
        reset_pin = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_wr", 32'(wr_rx), 32'd0);
        check("rst_wdata", 32'(w_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        snap = busy_cnt;
        repeat (1000) @(negedge clk);
        check("idle_busy_cycles", 32'(busy_cnt - snap), 32'd0);

        // Single good frame with latency window.
        send_frame(8'hA5, 1'b1, 0);
        lat = last_wr_cyc - fall_cyc;
        check("latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
        drain("a5");

        // Short low glitch is rejected at mid start bit.
        snap = busy_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_cnt > snap), 32'd1);
        drain("glitch");

        // Framing error with held-low break, then recovery.
        send_frame(8'h3C, 1'b0, 300);
        drain("brk");
        send_frame(8'h5A, 1'b1, 0);
        drain("after_brk");
        pulse_clear("clr_ferr");

        // Overrun while FIFO full; flag stays until cleared.
        @(negedge clk);
        fifo_full = 1'b1;
        send_frame(8'hFF, 1'b1, 0);
        fifo_full = 1'b0;
        drain("ovr");
        send_frame(8'h01, 1'b1, 0);
        drain("after_ovr");
        pulse_clear("clr_oerr");

        // Asynchronous reset in the middle of the data bits.
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * BIT_CYC) @(negedge clk);
        reset_pin = 1'b0;
        #1;
        check("midrst_wr", 32'(wr_rx), 32'd0);
        check("midrst_wdata", 32'(w_data), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overrun_err", 32'(overrun_err), 32'd0);
        exp_ferr = 1'b0;
        exp_oerr = 1'b0;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        reset_pin = 1'b1;
        repeat (12 * BIT_CYC) @(negedge clk);
        drain("midrst");
        send_frame(8'h12, 1'b1, 0);
        drain("after_rst");

        // Random frames against the model.
        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            good = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            fifo_full = full;
            send_frame(d, good, good ? 0 : int'($urandom_range(0, 100)));
            fifo_full = 1'b0;
            drain("rand");
            if ($urandom_range(0, 2) == 0) pulse_clear("rand_clr");
        end

        check("wr_single_cycle", 32'(double_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
